conv3x3_mac: RTL
================

// Module: conv3x3_mac
// PURPOSE
// - Consumer stage downstream of the image RAM write port. Once the image buffer is loaded, it reads
//   the NUM_TAPS image words and NUM_TAPS kernel weights, one tap per cycle, and accumulates the
//   signed products.
// - Output is the scaled, saturated dot product, offered on a valid/ready port to the next
//   layer (activation/pooling).
// PARAMETERS
// NUM_TAPS   9   window size (3x3 kernel); also the number of image/weight words read
// ADDR_W     4   image and weight read-address width; 2^ADDR_W >= NUM_TAPS
// DATA_W     16  signed pixel, weight and result width
// ACC_W      36  accumulator width = 2*DATA_W + ceil(log2(NUM_TAPS)); no internal overflow
// FRAC_BITS  0   arithmetic right shift applied to the accumulator before saturation
// PORTS
// clk        in   1       single clock, rising edge
// rst_n      in   1       asynchronous active-low reset
// start      in   1       pulse: image buffer complete, begin one convolution
// busy       out  1       high from the start acceptance until the result handshake completes
// img_raddr  out  ADDR_W  image RAM read address (RAM read is combinational, same cycle)
// img_rdata  in   DATA_W  signed image word at img_raddr
// w_raddr    out  ADDR_W  weight ROM read address (combinational read)
// w_rdata    in   DATA_W  signed weight at w_raddr
// res_data   out  DATA_W  signed saturated result
// res_valid  out  1       result available
// res_ready  in   1       downstream accepts result
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, acc=0, tap=0.
//   Outputs: busy=0, res_valid=0, res_data=0, img_raddr=0, w_raddr=0.
//   This reset applies immediately, including mid-operation, and any partial sum is discarded.
// - FSM IDLE -> ACC -> OUT -> IDLE.
//   - IDLE: start=1 sampled -> acc<=0, tap<=0, go to ACC. busy goes high on the next cycle.
//   - ACC: img_raddr = w_raddr = tap. Each edge does acc <= acc + img_rdata*w_rdata
//     (signed DATA_W x DATA_W, sign-extended to ACC_W) and tap <= tap+1.
//     On the edge where tap==NUM_TAPS-1: res_data <= sat(acc_final), res_valid <= 1, go to OUT.
//   - OUT: res_data and res_valid are held stable while res_ready=0 (unbounded backpressure).
//     When res_valid & res_ready: res_valid <= 0, busy <= 0, go to IDLE.
// - Latency: the first result edge is exactly NUM_TAPS edges after the edge that samples start.
//   Total occupancy is NUM_TAPS+1 cycles with zero backpressure.
// - start is ignored in ACC and OUT, including the OUT handshake cycle; no queueing.
//   A new convolution requires a fresh start in IDLE.
// - Address ordering: taps 0..NUM_TAPS-1 ascending, one per cycle. Outside ACC, addresses are held at 0.
// - Scaling: s = acc_final >>> FRAC_BITS (arithmetic shift, truncation toward -inf).
//   If s > 2^(DATA_W-1)-1, the result is 2^(DATA_W-1)-1.
//   If s < -2^(DATA_W-1), the result is -2^(DATA_W-1).
//   Otherwise the result is s[DATA_W-1:0].
// - tap never exceeds NUM_TAPS-1. No address wrap occurs inside a window.
// STRUCTURE
// - Shared package conv_pkg: DATA_W/ADDR_W/ACC_W defaults, NUM_TAPS, FSM state encoding
//   (IDLE=2'd0, ACC=2'd1, OUT=2'd2), SAT_MAX/SAT_MIN constants.
// - Sub-module sat_shift (combinational): ACC_W in -> shift by FRAC_BITS -> saturate -> DATA_W out.
//   Reused by later layers.
// - Top: FSM, tap counter, accumulator register, output register. One multiplier is inferred;
//   DSP mapping is acceptable.
// TESTING
// 1. Image all 1, weights all 1, FRAC_BITS=0, start pulse, res_ready=1
//    -> addrs 0..8 on 9 consecutive cycles; res_valid 9 edges after start; res_data=9; busy low next cycle.
// 2. FRAC_BITS=8, image all 0x0100, weights all 0x0100
//    -> acc=9*65536, res_data=0x0900. Repeat with weights 0xFF00 (-1.0) -> res_data=0xF700.
// 3. Saturation, FRAC_BITS=8: image and weights all 0x7FFF -> 0x7FFF.
//    Image 0x7FFF with weights 0x8000 -> 0x8000.
// 4. Backpressure: hold res_ready=0 for 5 cycles after res_valid, pulse start twice meanwhile
//    -> res_data stable, busy=1, starts ignored. Then res_ready=1 -> exactly one transfer, return to IDLE.
// 5. Reset mid-ACC (rst_n low at tap=4, asynchronous to clk)
//    -> all outputs 0 immediately. Then a fresh start with image=2, weights=3, FRAC_BITS=0 -> res_data=54.
// 6. Mixed signs: image = [1,-2,3,-4,5,-6,7,-8,9], weights all 1, FRAC_BITS=0
//    -> res_data=5. Back-to-back: start in the cycle after the handshake -> second identical result.

Source files
------------

// File: rtl/conv3x3_mac_pkg.sv
// Shared types and constants for the 3x3 convolution MAC stage.
// Consumed by the top, the saturation helper and the testbench.
package conv_pkg;
  localparam int NUM_TAPS = 9;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 16;
  localparam int ACC_W    = 36;

  localparam logic signed [DATA_W-1:0] SAT_MAX =
    {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SAT_MIN =
    {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;
endpackage

// File: rtl/conv3x3_mac_if.sv
// Result handshake bundle: valid/ready with signed payload.
// master drives data/valid, slave drives ready.
interface conv3x3_mac_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  modport master (
    output res_data,
    output res_valid,
    input  res_ready
  );

  modport slave (
    input  res_data,
    input  res_valid,
    output res_ready
  );
endinterface

// File: rtl/conv3x3_mac_sat_shift.sv
// Arithmetic right shift of a wide accumulator, then clamp
// to the signed DATA_W range.
module sat_shift
  import conv_pkg::*;
#(
  parameter int ACC_W     = conv_pkg::ACC_W,
  parameter int FRAC_BITS = 0
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] res
);
  localparam logic signed [ACC_W-1:0] HI =
    ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO =
    ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] s;

  always_comb begin
    s = acc >>> FRAC_BITS;
    if (s > HI)
      res = SAT_MAX;
    else if (s < LO)
      res = SAT_MIN;
    else
      res = s[DATA_W-1:0];
  end
endmodule

// File: rtl/conv3x3_mac.sv
// Sequential 3x3 MAC: one tap per cycle over image/weight
// memories, scaled and saturated result on a valid/ready port.
module conv3x3_mac
  import conv_pkg::*;
#(
  parameter int NUM_TAPS  = conv_pkg::NUM_TAPS,
  parameter int ADDR_W    = conv_pkg::ADDR_W,
  parameter int DATA_W    = conv_pkg::DATA_W,
  parameter int ACC_W     = conv_pkg::ACC_W,
  parameter int FRAC_BITS = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] img_raddr,
  input  logic [DATA_W-1:0] img_rdata,
  output logic [ADDR_W-1:0] w_raddr,
  input  logic [DATA_W-1:0] w_rdata,
  conv3x3_mac_if.master     res
);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_TAPS - 1);

  state_t                    state;
  logic [ADDR_W-1:0]         tap;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_next;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]  sat_res;

  // tap is parked at 0 outside ACC, so addresses follow it
  assign img_raddr = tap;
  assign w_raddr   = tap;

  assign prod     = $signed(img_rdata) * $signed(w_rdata);
  assign acc_next = acc + ACC_W'(prod);

  sat_shift #(
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_sat (
    .acc(acc_next),
    .res(sat_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tap           <= '0;
      acc           <= '0;
      busy          <= 1'b0;
      res.res_valid <= 1'b0;
      res.res_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            tap   <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          acc <= acc_next;
          if (tap == LAST) begin
            tap           <= '0;
            res.res_data  <= sat_res;
            res.res_valid <= 1'b1;
            state         <= OUT;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        OUT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
